// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of it.
// Bytes arrive over a valid/ready handshake and are sent LSB first as
// start bit, PAYLOAD_BITS data bits, then STOP_BITS stop bits. Every bit
// lasts CLK_HZ/BIT_RATE clock cycles. Queued frames go out back to back.
module uart_tx_fifo #(
  parameter int BIT_RATE     = 11520,
  parameter int CLK_HZ       = 50000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int STOP_CYC = STOP_BITS * CPB;
  localparam int CW       = $clog2(STOP_CYC + 1);
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int LW       = PW + 1;

  localparam logic [CW-1:0] CPB_LAST   = CW'(CPB - 1);
  localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_CYC - 1);
  localparam logic [2:0]    BIT_LAST   = 3'(PAYLOAD_BITS - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  // Parameter sets the counters and FIFO indexing cannot represent are
  // rejected when the design is elaborated.
  if (CPB < 2) begin : g_cpbCheck
    $error("uart_tx_fifo: CLK_HZ/BIT_RATE must be at least 2");
  end
  if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8) begin : g_payloadCheck
    $error("uart_tx_fifo: PAYLOAD_BITS must be in 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stopCheck
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depthCheck
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // FIFO state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;

  // Serialiser state
  state_e        state_q;
  logic [7:0]    shift_q;
  logic [CW-1:0] bitCnt_q;
  logic [2:0]    bitIdx_q;
  logic          txd_q;

  logic          fifoFull;
  logic          fifoEmpty;
  logic          push;
  logic          pop;
  logic [7:0]    headData;

  assign fifoFull  = (level_q == LEVEL_FULL);
  assign fifoEmpty = (level_q == '0);
  assign tx_ready  = !fifoFull;
  assign push      = tx_valid && !fifoFull;
  assign headData  = mem_q[rdPtr_q];

  // The serialiser takes the head byte when idle, or at the last cycle of
  // the stop period so the next start bit follows with no idle gap.
  assign pop = !fifoEmpty &&
               ((state_q == IDLE) || (state_q == STOP && bitCnt_q == STOP_LAST));

  // Next pointer and level values; a push and pop on the same edge leave
  // the level unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= tx_data;
    end
  end

  // Frame sequencer: the line bit is registered alongside the state so
  // the pin never glitches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
      bitIdx_q <= '0;
      txd_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q    <= 1'b1;
          bitCnt_q <= '0;
          bitIdx_q <= '0;
          if (pop) begin
            shift_q <= headData;
            state_q <= START;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (bitCnt_q == CPB_LAST) begin
            bitCnt_q <= '0;
            bitIdx_q <= '0;
            state_q  <= DATA;
            txd_q    <= shift_q[0];
          end else begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bitCnt_q == CPB_LAST) begin
            bitCnt_q <= '0;
            if (bitIdx_q == BIT_LAST) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              shift_q  <= shift_q >> 1;
              bitIdx_q <= bitIdx_q + 1'b1;
              txd_q    <= shift_q[1];
            end
          end else begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bitCnt_q == STOP_LAST) begin
            bitCnt_q <= '0;
            bitIdx_q <= '0;
            if (pop) begin
              shift_q <= headData;
              state_q <= START;
              txd_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign uart_txd   = txd_q;
  assign fifo_level = level_q;
  assign tx_busy    = (state_q != IDLE) || (level_q != '0);

endmodule
